// File: rtl/demorgan_pkg.sv
// demorgan_pkg: shared types and constants for the demorgan_sweep checker.
//   state_e      - sweep FSM states
//   NUM_VECTORS  - number of (a,b) combinations driven per sweep
//   BIT_*        - bit positions of the six gate outputs in the expected,
//                  actual and mismatch vectors
//                  {n_a_and_b, n_a_or_n_b, n_a_or_b, n_a_and_n_b, n_b, n_a}
package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 4;
  localparam int MASK_W      = 6;

  localparam int BIT_N_A         = 0;
  localparam int BIT_N_B         = 1;
  localparam int BIT_N_A_AND_N_B = 2;
  localparam int BIT_N_A_OR_B    = 3;
  localparam int BIT_N_A_OR_N_B  = 4;
  localparam int BIT_N_A_AND_B   = 5;

endpackage

// File: rtl/demorgan_expect.sv
// demorgan_expect: combinational reference for the demorgan gate block.
//   a_i, b_i : stimulus bits
//   exp_o    : expected gate outputs, bit order from demorgan_pkg BIT_*
// Each De Morgan pair shares one expected value, so comparing both members
// against it also checks the identity between them.
module demorgan_expect
  import demorgan_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [MASK_W-1:0] exp_o
);

  always_comb begin
    exp_o                  = '0;
    exp_o[BIT_N_A]         = ~a_i;
    exp_o[BIT_N_B]         = ~b_i;
    exp_o[BIT_N_A_AND_N_B] = ~a_i & ~b_i;
    exp_o[BIT_N_A_OR_B]    = ~(a_i | b_i);
    exp_o[BIT_N_A_OR_N_B]  = ~a_i | ~b_i;
    exp_o[BIT_N_A_AND_B]   = ~(a_i & b_i);
  end

endmodule

// File: rtl/demorgan_sweep.sv
// demorgan_sweep: stimulus sequencer and checker for the demorgan gate block.
// On start it drives (a,b) = 00, 01, 10, 11, holds each for SETTLE_CYCLES,
// samples the six gate outputs and records errors.
//   clk, reset (sync, active-high), start       : control inputs
//   n_a .. n_a_and_b                             : gate outputs under test
//   a, b                                         : registered stimulus
//   busy, done, pass                             : sweep status
//   err_count, fail_vec, fail_mask               : error summary
//
// state  | meaning
// IDLE   | outputs hold, waiting for start
// SETTLE | current vector applied, counting down the settle time
// CHECK  | sample gate outputs, record mismatch, advance vector
// DONE   | one-cycle done pulse, then back to IDLE
module demorgan_sweep
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              n_a,
  input  logic              n_b,
  input  logic              n_a_and_n_b,
  input  logic              n_a_or_b,
  input  logic              n_a_or_n_b,
  input  logic              n_a_and_b,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_count,
  output logic [1:0]        fail_vec,
  output logic [MASK_W-1:0] fail_mask
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("demorgan_sweep: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [1:0]       LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         vec_q;
  logic               a_q, b_q;
  logic               busy_q, done_q, pass_q;
  logic [2:0]         err_q, err_d;
  logic [1:0]         fvec_q;
  logic [MASK_W-1:0]  fmask_q;

  logic [MASK_W-1:0]  exp_v;
  logic [MASK_W-1:0]  act_v;
  logic [MASK_W-1:0]  mismatch;

  demorgan_expect u_expect (
    .a_i   (a_q),
    .b_i   (b_q),
    .exp_o (exp_v)
  );

  assign act_v = {n_a_and_b, n_a_or_n_b, n_a_or_b, n_a_and_n_b, n_b, n_a};

  // Case inequality so an X/Z on a gate output counts as a mismatch.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < MASK_W; i++) begin
      mismatch[i] = (act_v[i] !== exp_v[i]);
    end
  end

  assign err_d = (|mismatch) ? err_q + 3'd1 : err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fmask_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fmask_q <= '0;
            pass_q  <= 1'b0;
            cnt_q   <= SETTLE_LOAD;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          // <= rather than == keeps a corrupted zero count from hanging here
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (|mismatch) begin
            err_q <= err_d;
            if (err_q == 3'd0) begin
              fvec_q  <= {a_q, b_q};
              fmask_q <= mismatch;
            end
          end
          if (vec_q == LAST_VEC) begin
            // pass is presented together with done and already includes
            // the outcome of this final check
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
            state_q <= DONE;
          end else begin
            vec_q      <= vec_q + 2'd1;
            {a_q, b_q} <= vec_q + 2'd1;
            cnt_q      <= SETTLE_LOAD;
            state_q    <= SETTLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;

endmodule

// File: tb/tb_demorgan_sweep.sv
// tb_demorgan_sweep: directed bench for demorgan_sweep with a behavioural
// gate model that can be switched into two faulty modes.
module tb_demorgan_sweep;

  typedef struct {
    logic [2:0] err;
    logic [1:0] fvec;
    logic [5:0] fmask;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  int   fm = 0;

  int errors = 0;
  int checks = 0;
  res_t sb_q[$];

  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] fv1;
  logic [5:0] fmk1;
  logic [5:0] act1;

  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [1:0] fv3;
  logic [5:0] fmk3;
  logic [5:0] act3;

  always #5 clk = ~clk;

  // Golden gate outputs, order {n_a_and_b, n_a_or_n_b, n_a_or_b, n_a_and_n_b, n_b, n_a}
  function automatic logic [5:0] golden(input logic ga, input logic gb);
    logic [5:0] g;
    g[0] = !ga;
    g[1] = !gb;
    g[2] = (!ga) && (!gb);
    g[3] = !(ga || gb);
    g[4] = (!ga) || (!gb);
    g[5] = !(ga && gb);
    return g;
  endfunction

  // Gate model seen by the checker: mode 1 = n_a_or_b stuck at 0,
  // mode 2 = n_a_and_b inverted.
  function automatic logic [5:0] gate_model(input logic ga, input logic gb, input int mode);
    logic [5:0] g;
    g = golden(ga, gb);
    if (mode == 1) g[3] = 1'b0;
    if (mode == 2) g[5] = ~g[5];
    return g;
  endfunction

  assign act1 = gate_model(a1, b1, fm);
  assign act3 = gate_model(a3, b3, fm);

  demorgan_sweep #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .n_a(act1[0]), .n_b(act1[1]), .n_a_and_n_b(act1[2]),
    .n_a_or_b(act1[3]), .n_a_or_n_b(act1[4]), .n_a_and_b(act1[5]),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1), .fail_mask(fmk1)
  );

  demorgan_sweep #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .n_a(act3[0]), .n_b(act3[1]), .n_a_and_n_b(act3[2]),
    .n_a_or_b(act3[3]), .n_a_or_n_b(act3[4]), .n_a_and_b(act3[5]),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fv3), .fail_mask(fmk3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic push_expect(input int mode);
    res_t r;
    logic [5:0] mm;
    logic va, vb;
    r.err = 0; r.fvec = 0; r.fmask = 0;
    for (int v = 0; v < 4; v++) begin
      va = (v >= 2);
      vb = (v % 2 == 1);
      mm = golden(va, vb) ^ gate_model(va, vb, mode);
      if (mm != 0) begin
        if (r.err == 0) begin
          r.fvec  = 2'(v);
          r.fmask = mm;
        end
        r.err = r.err + 3'd1;
      end
    end
    r.pass = (r.err == 0);
    sb_q.push_back(r);
  endtask

  task automatic pop_check(input bit inst);
    res_t r;
    if (sb_q.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      r = sb_q.pop_front();
      check("err_count", 8'(inst ? err3 : err1), 8'(r.err));
      check("fail_vec",  8'(inst ? fv3 : fv1),   8'(r.fvec));
      check("fail_mask", 8'(inst ? fmk3 : fmk1), 8'(r.fmask));
      check("pass",      8'(inst ? pass3 : pass1), 8'(r.pass));
    end
  endtask

  task automatic check_reset_vals(input bit inst);
    check("rst_a",     8'(inst ? a3 : a1), 8'd0);
    check("rst_b",     8'(inst ? b3 : b1), 8'd0);
    check("rst_busy",  8'(inst ? busy3 : busy1), 8'd0);
    check("rst_done",  8'(inst ? done3 : done1), 8'd0);
    check("rst_pass",  8'(inst ? pass3 : pass1), 8'd0);
    check("rst_err",   8'(inst ? err3 : err1), 8'd0);
    check("rst_fvec",  8'(inst ? fv3 : fv1), 8'd0);
    check("rst_fmask", 8'(inst ? fmk3 : fmk1), 8'd0);
  endtask

  // Full sweep: checks cleared results, per-cycle stimulus, busy, latency
  // and the scoreboard entry at done.
  task automatic run_sweep(input bit inst, input int settle, input int mode);
    int lat, cyc, idx;
    bit got;
    lat = 4 * (settle + 1) + 1;
    fm = mode;
    push_expect(mode);
    if (inst) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    check("clr_err",   8'(inst ? err3 : err1), 8'd0);
    check("clr_fvec",  8'(inst ? fv3 : fv1), 8'd0);
    check("clr_fmask", 8'(inst ? fmk3 : fmk1), 8'd0);
    check("clr_pass",  8'(inst ? pass3 : pass1), 8'd0);
    got = 0;
    cyc = 1;
    while (!got && cyc <= 80) begin
      idx = (cyc - 1) / (settle + 1);
      if (idx > 3) idx = 3;
      check("ab", 8'(inst ? {a3, b3} : {a1, b1}), 8'(idx[1:0]));
      check("busy", 8'(inst ? busy3 : busy1), 8'd1);
      if (inst ? done3 : done1) begin
        got = 1;
        check("done_latency", 8'(cyc), 8'(lat));
        pop_check(inst);
      end else begin
        tick();
        cyc++;
      end
    end
    if (!got) fail_now("done_wait");
    tick();
    check("done_pulse_end", 8'(inst ? done3 : done1), 8'd0);
    check("busy_end", 8'(inst ? busy3 : busy1), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit got;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);
    tick();

    // correct gate, then the two faulty gates, then longer settle time
    run_sweep(0, 1, 0);
    run_sweep(0, 1, 1);
    run_sweep(0, 1, 2);
    run_sweep(1, 3, 0);
    run_sweep(1, 3, 2);

    // start re-pulsed while busy and in the DONE cycle is ignored
    fm = 0;
    push_expect(0);
    start1 = 1'b1;
    tick();                      // cycle 1
    start1 = 1'b0;
    tick();                      // cycle 2
    start1 = 1'b1;
    tick();                      // cycle 3
    start1 = 1'b0;
    check("repulse_busy", 8'(busy1), 8'd1);
    check("repulse_ab", 8'({a1, b1}), 8'd1);
    repeat (5) tick();           // cycle 8
    check("repulse_no_early_done", 8'(done1), 8'd0);
    tick();                      // cycle 9
    check("repulse_done", 8'(done1), 8'd1);
    check("repulse_busy_done", 8'(busy1), 8'd1);
    pop_check(0);
    start1 = 1'b1;
    tick();                      // cycle 10
    start1 = 1'b0;
    check("start_in_done_ignored", 8'(busy1), 8'd0);
    check("no_second_done", 8'(done1), 8'd0);
    check("pass_held", 8'(pass1), 8'd1);
    fm = 2;
    push_expect(2);
    start1 = 1'b1;
    tick();                      // cycle 11
    start1 = 1'b0;
    check("restart_busy", 8'(busy1), 8'd1);
    check("restart_pass_clr", 8'(pass1), 8'd0);
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      if (done1) got = 1;
      else begin
        tick();
        n++;
      end
    end
    if (!got) fail_now("restart_done_wait");
    else begin
      check("restart_latency", 8'(n), 8'd8);
      pop_check(0);
    end
    tick();

    // reset in the middle of a sweep
    fm = 0;
    start1 = 1'b1;
    tick();                      // cycle 1
    start1 = 1'b0;
    repeat (4) tick();           // cycle 5
    check("pre_reset_busy", 8'(busy1), 8'd1);
    reset = 1'b1;
    tick();                      // cycle 6
    reset = 1'b0;
    check_reset_vals(0);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1 || busy1) got = 1;
    end
    check("no_done_after_reset", 8'(got), 8'd0);
    run_sweep(0, 1, 0);

    if (sb_q.size() != 0) fail_now("scoreboard_leftover");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
